fft_out_serializer: RTL and testbench
=====================================

# fft_out_serializer

Output-side consumer for the 8-point FFT datapath. It captures one complete frame of eight complex results, presented in parallel in bit-reversed lane order, into a two-slot ping-pong buffer. It then streams the frame out one complex sample per beat in natural bin order (0..7) over a valid/ready handshake. It sits after the final FFT stage and decouples the fixed-rate parallel datapath from a serial downstream sink.

## Interface
- N, default 4: word-width exponent; data words are W = 2**N bits (16 by default), two's complement.
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-high reset.
- in_valid  input  1: parallel frame present on xr*/xi*.
- in_ready  output  1: a buffer slot is free; frame captured when in_valid && in_ready.
- xr0..xr7  input  W each: real part, lane k.
- xi0..xi7  input  W each: imaginary part, lane k.
- out_valid  output  1: out_re/out_im/out_idx/out_last hold a valid beat.
- out_ready  input  1: sink accepts the beat when out_valid && out_ready.
- out_re  output  W: real part of current bin.
- out_im  output  W: imaginary part of current bin.
- out_idx  output  3: bin number of current beat, 0..7.
- out_last  output  1: high on the bin-7 beat only.

## Operation
- Lane mapping:
  - Input lane k carries bin bitrev3(k).
  - Output bin j is read from lane bitrev3(j); the read order of lanes is 0,4,2,6,1,5,3,7.
- Storage:
  - Two slots, each 8 × (re, im) registers.
  - wr_ptr and rd_ptr are 1 bit each; count ranges 0..2.
- Capture:
  - On in_valid && in_ready, all 16 words are written into slot wr_ptr and wr_ptr toggles.
  - The frame is captured unmodified; no arithmetic, no width change.
- Emit:
  - out_valid = (count != 0).
  - out_re/out_im come from slot rd_ptr, lane bitrev3(rd_idx).
  - out_idx = rd_idx; out_last = out_valid && (rd_idx == 7).
  - On each handshake rd_idx increments.
  - On the out_last handshake: rd_idx wraps to 0, rd_ptr toggles, and the slot is freed.
- count update:
  - +1 on capture.
  - −1 on last-beat handshake.
  - Unchanged when both occur in the same cycle.
- in_ready = (count != 2).
  - Depends on registered state only; no combinational path from out_ready to in_ready.
  - A full buffer therefore does not accept a frame in the same cycle as a last-beat pop; acceptance happens the following cycle.
- Source rule: in_valid with in_ready low means the source holds the frame and its values stable. Nothing is dropped.
- Backpressure: while out_valid && !out_ready, all out_* values are held stable.

## Timing
- Reset (asynchronous, takes effect immediately):
  - count=0, wr_ptr=0, rd_ptr=0, rd_idx=0.
  - All storage = 0.
  - Hence in_ready=1, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0.
- Latency: a frame captured at edge E presents bin 0 on out_* in the cycle after E. out_valid is high from E onward if count was 0.
- Throughput:
  - 8 beats per frame with out_ready held high.
  - Sustained one frame per 8 cycles, with no bubble between frames when the next frame is already buffered.
- Reset mid-frame: any partial frame is discarded and emission restarts at bin 0 of the next captured frame.
- All outputs are driven from registers through the read mux. There are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - W derived from N.
  - FRAME_LEN = 8.
  - Slot count 2.
  - bitrev3 function (0↔0, 1↔4, 2↔2, 3↔6, 5↔5, 7↔7).
- One natural sub-module, fft_frame_slot: the 8-lane re/im register bank with write-all-lanes enable and 3-bit read select (bit-reverse applied inside). Instantiated twice.
- The top level holds the pointers, count, rd_idx and handshake logic.

## Test plan
- Reset: assert rst with no clock → in_ready=1, out_valid=0, out_re=out_im=0, out_last=0.
- Single frame:
  - Stimulus: xr_k = 16'h0010*k + 1, xi_k = −k; out_ready=1.
  - Response: 8 consecutive beats starting the cycle after capture.
  - out_re = 0x0001, 0x0041, 0x0021, 0x0061, 0x0011, 0x0051, 0x0031, 0x0071.
  - out_idx = 0..7; out_last only on beat 8; out_valid low after.
- Backpressure: drop out_ready for 3 cycles during beat 2 → out_re/out_im/out_idx=2 held constant; sequence resumes unchanged with no missing or repeated beat.
- Full buffer:
  - Stimulus: out_ready=0, offer frames A, B, C back-to-back.
  - Response: A and B accepted; in_ready=0 with C held.
  - Then raise out_ready → C accepted the cycle after A's out_last handshake; output order A then B then C.
- Simultaneous capture and pop:
  - Stimulus: count=1, a new frame offered on the cycle of the last beat.
  - Response: count stays 1, out_valid never drops, and bin 0 of the new frame appears the next cycle.
- Mid-frame reset: assert rst after 3 beats → out_valid=0 and in_ready=1 immediately; the next frame streams from bin 0 correctly.

Source files
------------

// File: rtl/fft_out_serializer_pkg.sv
// Shared constants and helpers for the FFT output serializer.
package fft_out_serializer_pkg;

    // Default word-width exponent; data words are 2**N bits wide.
    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 2 ** N_DEFAULT;

    // One FFT frame is eight complex samples, double-buffered.
    localparam int FRAME_LEN = 8;
    localparam int NUM_SLOTS = 2;
    localparam int IDX_W     = 3;

    typedef logic [IDX_W-1:0] bin_idx_t;
    typedef logic [1:0]       slot_count_t;

    localparam slot_count_t COUNT_FULL = slot_count_t'(NUM_SLOTS);
    localparam bin_idx_t    LAST_BIN   = bin_idx_t'(FRAME_LEN - 1);

    // Word width for a given exponent.
    function automatic int word_width(input int n);
        return 2 ** n;
    endfunction

    // 3-bit bit reversal: lane k of the FFT carries bin bitrev3(k), and vice versa.
    function automatic bin_idx_t bitrev3(input bin_idx_t v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/fft_out_serializer_slot.sv
// One frame slot: eight lanes of (re, im) registers, written all at once,
// read one bin at a time with the bit-reverse lane mapping applied here.
module fft_frame_slot
    import fft_out_serializer_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_re [FRAME_LEN],
    input  logic [W-1:0] wr_im [FRAME_LEN],
    input  bin_idx_t     rd_bin,
    output logic [W-1:0] rd_re,
    output logic [W-1:0] rd_im
);

    logic [W-1:0] lane_re [FRAME_LEN];
    logic [W-1:0] lane_im [FRAME_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_lane
            logic [W-1:0] re_q, re_d;
            logic [W-1:0] im_q, im_d;

            // Load the lane from the parallel input when the slot is written.
            always_comb begin
                re_d = re_q;
                im_d = im_q;
                if (wr_en) begin
                    re_d = wr_re[gi];
                    im_d = wr_im[gi];
                end
            end

            // Lane storage; cleared so a fresh reset presents zeros on the outputs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    re_q <= '0;
                    im_q <= '0;
                end else begin
                    re_q <= re_d;
                    im_q <= im_d;
                end
            end

            assign lane_re[gi] = re_q;
            assign lane_im[gi] = im_q;
        end
    endgenerate

    // Bin j lives in lane bitrev3(j).
    always_comb begin
        rd_re = lane_re[bitrev3(rd_bin)];
        rd_im = lane_im[bitrev3(rd_bin)];
    end

endmodule

// File: rtl/fft_out_serializer.sv
// Captures bit-reversed parallel FFT frames into a ping-pong buffer and
// streams them out one bin per beat in natural order over valid/ready.
module fft_out_serializer
    import fft_out_serializer_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int W = word_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] xr0,
    input  logic [W-1:0] xr1,
    input  logic [W-1:0] xr2,
    input  logic [W-1:0] xr3,
    input  logic [W-1:0] xr4,
    input  logic [W-1:0] xr5,
    input  logic [W-1:0] xr6,
    input  logic [W-1:0] xr7,
    input  logic [W-1:0] xi0,
    input  logic [W-1:0] xi1,
    input  logic [W-1:0] xi2,
    input  logic [W-1:0] xi3,
    input  logic [W-1:0] xi4,
    input  logic [W-1:0] xi5,
    input  logic [W-1:0] xi6,
    input  logic [W-1:0] xi7,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [2:0]   out_idx,
    output logic         out_last
);

    slot_count_t count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    bin_idx_t    rd_idx_q, rd_idx_d;

    logic         capture;
    logic         beat;
    logic         last_beat;
    logic [W-1:0] in_re   [FRAME_LEN];
    logic [W-1:0] in_im   [FRAME_LEN];
    logic [W-1:0] slot_re [NUM_SLOTS];
    logic [W-1:0] slot_im [NUM_SLOTS];

    assign in_re = '{xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7};
    assign in_im = '{xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            fft_frame_slot #(.W(W)) u_slot (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (capture && (wr_ptr_q == gi[0])),
                .wr_re  (in_re),
                .wr_im  (in_im),
                .rd_bin (rd_idx_q),
                .rd_re  (slot_re[gi]),
                .rd_im  (slot_im[gi])
            );
        end
    endgenerate

    // Handshake decode, output mux and next-state for pointers, count and bin index.
    always_comb begin
        in_ready  = (count_q != COUNT_FULL);
        out_valid = (count_q != '0);
        out_idx   = rd_idx_q;
        out_last  = out_valid && (rd_idx_q == LAST_BIN);
        out_re    = slot_re[rd_ptr_q];
        out_im    = slot_im[rd_ptr_q];

        capture   = in_valid && in_ready;
        beat      = out_valid && out_ready;
        last_beat = beat && out_last;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ capture;
        rd_ptr_d = rd_ptr_q ^ last_beat;
        rd_idx_d = beat ? rd_idx_q + bin_idx_t'(1) : rd_idx_q;

        // A capture and a frame release in the same cycle cancel out.
        if (capture && !last_beat) begin
            count_d = count_q + slot_count_t'(1);
        end else if (!capture && last_beat) begin
            count_d = count_q - slot_count_t'(1);
        end
    end

    // Control state; reset discards any buffered or partially sent frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_idx_q <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: directed scenarios plus random
// traffic, checked against a queue model of the frames awaiting emission.
module tb_fft_out_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] xr [8];
    logic [W-1:0] xi [8];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic [2:0]   out_idx;
    logic         out_last;

    // Reference model: bins still to be emitted, in natural order, plus the bin index.
    logic [W-1:0] mre [$];
    logic [W-1:0] mim [$];
    int           midx = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fft_out_serializer #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xr0 (xr[0]), .xr1 (xr[1]), .xr2 (xr[2]), .xr3 (xr[3]),
        .xr4 (xr[4]), .xr5 (xr[5]), .xr6 (xr[6]), .xr7 (xr[7]),
        .xi0 (xi[0]), .xi1 (xi[1]), .xi2 (xi[2]), .xi3 (xi[3]),
        .xi4 (xi[4]), .xi5 (xi[5]), .xi6 (xi[6]), .xi7 (xi[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Bin j of a frame arrives on lane (bits of j reversed).
    function automatic int brev(input int j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) begin
            xr[k] = W'($urandom);
            xi[k] = W'($urandom);
        end
    endtask

    // Advance the model by one clock edge (no checking here).
    task automatic advance(input bit cap, input bit pop);
        if (pop) begin
            void'(mre.pop_front());
            void'(mim.pop_front());
            midx = (midx + 1) % 8;
        end
        if (cap) begin
            for (int j = 0; j < 8; j++) begin
                mre.push_back(xr[brev(j)]);
                mim.push_back(xi[brev(j)]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            xr[k] = '0;
            xi[k] = '0;
        end
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_re !== '0) begin n_bad++; $display("FAIL reset_out_re got=%h want=0", out_re); end
        n_cmp++; if (out_im !== '0) begin n_bad++; $display("FAIL reset_out_im got=%h want=0", out_im); end
        n_cmp++; if (out_idx !== 3'd0) begin n_bad++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        $display("reset: checked idle outputs");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        logic [W-1:0] exp_re [8];
        exp_re = '{16'h0001, 16'h0041, 16'h0021, 16'h0061, 16'h0011, 16'h0051, 16'h0031, 16'h0071};
        for (int k = 0; k < 8; k++) begin
            xr[k] = W'(16 * k + 1);
            xi[k] = W'(-k);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_re, out_im, out_idx, out_last} !==
                {1'b1, exp_re[b], W'(-brev(b)), 3'(b), (b == 7)}) begin
                n_bad++;
                $display("FAIL single_beat%0d got=v%b re=%h im=%h idx=%0d last=%b want=v1 re=%h im=%h idx=%0d last=%b",
                         b, out_valid, out_re, out_im, out_idx, out_last, exp_re[b], W'(-brev(b)), b, (b == 7));
            end
            $display("single: beat %0d re=%h im=%h idx=%0d last=%b", b, out_re, out_im, out_idx, out_last);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_after got=%b want=0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ev, er, cap, pop;
        int stalls = 0;
        rand_frame();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            ev = (mre.size() != 0);
            er = ((mre.size() + 7) / 8) != 2;
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL bp_valid c=%0d got=%b want=%b", c, out_valid, ev); end
            n_cmp++; if (in_ready !== er) begin n_bad++; $display("FAIL bp_in_ready c=%0d got=%b want=%b", c, in_ready, er); end
            if (ev) begin
                n_cmp++;
                if ({out_re, out_im, out_idx, out_last} !== {mre[0], mim[0], 3'(midx), (midx == 7)}) begin
                    n_bad++;
                    $display("FAIL bp_beat c=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", c,
                             out_re, out_im, out_idx, out_last, mre[0], mim[0], midx, (midx == 7));
                end
            end
            $display("backpressure: c=%0d ready=%b valid=%b idx=%0d re=%h", c, out_ready, out_valid, out_idx, out_re);
            cap = in_valid && er;
            pop = ev && out_ready;
            @(posedge clk);
            advance(cap, pop);
            #1;
            if (cap) in_valid = 1'b0;
            out_ready = !(midx == 2 && stalls < 3 && mre.size() != 0);
            if (!out_ready) stalls++;
        end
        n_cmp++; if (stalls != 3) begin n_bad++; $display("FAIL bp_stall_count got=%0d want=3", stalls); end
        out_ready = 1'b1;
    endtask

    task automatic test_full_buffer();
        bit ev, er, cap, pop;
        int caps = 0;
        out_ready = 1'b0;
        rand_frame();
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ev = (mre.size() != 0);
            er = ((mre.size() + 7) / 8) != 2;
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL full_valid c=%0d got=%b want=%b", c, out_valid, ev); end
            n_cmp++; if (in_ready !== er) begin n_bad++; $display("FAIL full_in_ready c=%0d got=%b want=%b", c, in_ready, er); end
            if (ev) begin
                n_cmp++;
                if ({out_re, out_im, out_idx, out_last} !== {mre[0], mim[0], 3'(midx), (midx == 7)}) begin
                    n_bad++;
                    $display("FAIL full_beat c=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", c,
                             out_re, out_im, out_idx, out_last, mre[0], mim[0], midx, (midx == 7));
                end
            end
            $display("full: c=%0d in_valid=%b in_ready=%b out_valid=%b idx=%0d", c, in_valid, in_ready, out_valid, out_idx);
            cap = in_valid && er;
            pop = ev && out_ready;
            @(posedge clk);
            advance(cap, pop);
            #1;
            if (cap) begin
                caps++;
                if (caps < 3) rand_frame();
                else in_valid = 1'b0;
            end
            if (c >= 3) out_ready = 1'b1;
        end
        n_cmp++; if (caps != 3) begin n_bad++; $display("FAIL full_captures got=%0d want=3", caps); end
    endtask

    task automatic test_simultaneous();
        bit ev, er, cap, pop;
        int sent = 0;
        out_ready = 1'b1;
        rand_frame();
        in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ev = (mre.size() != 0);
            er = ((mre.size() + 7) / 8) != 2;
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL simul_valid c=%0d got=%b want=%b", c, out_valid, ev); end
            n_cmp++; if (in_ready !== er) begin n_bad++; $display("FAIL simul_in_ready c=%0d got=%b want=%b", c, in_ready, er); end
            if (ev) begin
                n_cmp++;
                if ({out_re, out_im, out_idx, out_last} !== {mre[0], mim[0], 3'(midx), (midx == 7)}) begin
                    n_bad++;
                    $display("FAIL simul_beat c=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", c,
                             out_re, out_im, out_idx, out_last, mre[0], mim[0], midx, (midx == 7));
                end
            end
            $display("simultaneous: c=%0d in_valid=%b out_valid=%b idx=%0d last=%b", c, in_valid, out_valid, out_idx, out_last);
            cap = in_valid && er;
            pop = ev && out_ready;
            @(posedge clk);
            advance(cap, pop);
            #1;
            if (cap) begin
                sent++;
                in_valid = 1'b0;
            end
            if (sent == 1 && midx == 7 && !in_valid) begin
                rand_frame();
                in_valid = 1'b1;
            end
        end
        n_cmp++; if (sent != 2) begin n_bad++; $display("FAIL simul_captures got=%0d want=2", sent); end
    endtask

    task automatic test_mid_reset();
        bit ev, er, cap, pop;
        out_ready = 1'b1;
        rand_frame();
        in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 4) begin
                // Three beats have been sent; reset asynchronously mid-cycle.
                rst = 1'b1;
                #1;
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
                n_cmp++; if (out_re !== '0) begin n_bad++; $display("FAIL midrst_out_re got=%h want=0", out_re); end
                n_cmp++; if (out_idx !== 3'd0) begin n_bad++; $display("FAIL midrst_out_idx got=%0d want=0", out_idx); end
                $display("mid_reset: reset asserted after 3 beats");
                mre.delete();
                mim.delete();
                midx = 0;
                #2;
                rst = 1'b0;
                rand_frame();
                in_valid = 1'b1;
            end
            @(negedge clk);
            ev = (mre.size() != 0);
            er = ((mre.size() + 7) / 8) != 2;
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL midrst_v c=%0d got=%b want=%b", c, out_valid, ev); end
            n_cmp++; if (in_ready !== er) begin n_bad++; $display("FAIL midrst_r c=%0d got=%b want=%b", c, in_ready, er); end
            if (ev) begin
                n_cmp++;
                if ({out_re, out_im, out_idx, out_last} !== {mre[0], mim[0], 3'(midx), (midx == 7)}) begin
                    n_bad++;
                    $display("FAIL midrst_beat c=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", c,
                             out_re, out_im, out_idx, out_last, mre[0], mim[0], midx, (midx == 7));
                end
            end
            $display("mid_reset: c=%0d out_valid=%b idx=%0d re=%h", c, out_valid, out_idx, out_re);
            cap = in_valid && er;
            pop = ev && out_ready;
            @(posedge clk);
            advance(cap, pop);
            #1;
            if (cap) in_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        bit ev, er, cap, pop;
        in_valid = 1'b0;
        for (int c = 0; c < 460; c++) begin
            @(negedge clk);
            ev = (mre.size() != 0);
            er = ((mre.size() + 7) / 8) != 2;
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, out_valid, ev); end
            n_cmp++; if (in_ready !== er) begin n_bad++; $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, in_ready, er); end
            if (ev) begin
                n_cmp++;
                if ({out_re, out_im, out_idx, out_last} !== {mre[0], mim[0], 3'(midx), (midx == 7)}) begin
                    n_bad++;
                    $display("FAIL rand_beat c=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", c,
                             out_re, out_im, out_idx, out_last, mre[0], mim[0], midx, (midx == 7));
                end
            end
            cap = in_valid && er;
            pop = ev && out_ready;
            $display("random: c=%0d cap=%b beat=%b idx=%0d re=%h im=%h", c, cap, pop, out_idx, out_re, out_im);
            @(posedge clk);
            advance(cap, pop);
            #1;
            // A held frame stays untouched until it is captured.
            if (!in_valid || cap) begin
                in_valid = (c < 400) && ($urandom_range(0, 2) != 0);
                if (in_valid) rand_frame();
            end
            out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rand_drained got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_full_buffer();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
